// File: rtl/assoc_cache_pkg.sv
// assoc_cache_pkg: FSM state type and store byte-merge helper shared by the cache.
package assoc_cache_pkg;
  typedef enum logic [1:0] {LOOKUP, WRITEBACK, REFILL} state_t;
  function automatic logic [31:0] merge_bytes(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [3:0] mask);
    for (int b = 0; b < 4; b++) if (mask[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
    return word;
  endfunction
endpackage

// File: rtl/assoc_cache_lru.sv
// assoc_cache_lru: next true-LRU ages for one set after touching way i_way.
module assoc_cache_lru #(
  parameter int WAYS = 2,
  localparam int AW = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AW-1:0] i_ages,
  input  logic [AW-1:0]           i_way,
  output logic [WAYS-1:0][AW-1:0] o_ages
);
  logic [AW-1:0] w_old;
  always_comb begin
    w_old = i_ages[i_way];
    for (int w = 0; w < WAYS; w++)
      o_ages[w] = (AW'(w) == i_way) ? '0 : (i_ages[w] < w_old) ? i_ages[w] + 1'b1 : i_ages[w];
  end
endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: set-associative write-back/write-allocate cache with true LRU.
// Define ASSOC_CACHE_STATS_EN to add hit/miss/writeback counters.
module assoc_cache
  import assoc_cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [31:0]           i_cpu_addr,
  input  logic [31:0]           i_cpu_wdata,
  input  logic [3:0]            i_cpu_byte_mask,
  output logic [31:0]           o_cpu_rdata,
  output logic                  o_cpu_ready,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [31:0]           o_mem_addr,
  output logic [WORDS*32-1:0]   o_mem_wdata,
  input  logic [WORDS*32-1:0]   i_mem_rdata,
  input  logic                  i_mem_ack
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0]           o_hit_count,
  output logic [31:0]           o_miss_count,
  output logic [31:0]           o_wb_count
`endif
);
  localparam int AW     = $clog2(WAYS);
  localparam int IW     = $clog2(SETS);
  localparam int IDX_LO = $clog2(WORDS) + 2;
  localparam int TW     = 32 - IDX_LO - IW;
  localparam int OW     = WORDS > 1 ? $clog2(WORDS) : 1;

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [AW-1:0]          age;
    logic [TW-1:0]          tag;
    logic [WORDS-1:0][31:0] block;
  } line_t;
  typedef line_t [SETS-1:0][WAYS-1:0] lines_t;

  function automatic lines_t rst_lines();
    lines_t l = '0;
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) l[s][w].age = AW'(w);
    return l;
  endfunction
  localparam lines_t RST_LINES = rst_lines();

  lines_t                   r_lines;
  state_t                   r_state, w_next;
  logic [AW-1:0]            r_victim, w_hit_way, w_vic, w_acc;
  logic                     r_mem_req, r_mem_we;
  logic [31:0]              r_mem_addr;
  logic [WORDS*32-1:0]      r_mem_wdata;
  logic [IW-1:0]            w_idx;
  logic [TW-1:0]            w_tag;
  logic [OW-1:0]            w_off;
  logic [31:0]              w_word;
  logic [WAYS-1:0][AW-1:0]  w_ages, w_new_ages;
  logic w_hit, w_lookup, w_hit_ok, w_miss, w_fill, w_wb_ack, w_upd, w_dirty_vic;

  assign w_idx = i_cpu_addr[IDX_LO +: IW];
  assign w_tag = i_cpu_addr[31 -: TW];
  assign w_off = OW'((i_cpu_addr >> 2) & 32'(WORDS - 1));

  // Victim: lowest-index invalid way wins over the oldest way.
  always_comb begin
    w_hit = 1'b0;
    w_hit_way = '0;
    w_vic = '0;
    w_ages = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_ages[w] = r_lines[w_idx][w].age;
      if (r_lines[w_idx][w].valid && r_lines[w_idx][w].tag == w_tag) begin
        w_hit = 1'b1;
        w_hit_way = AW'(w);
      end
      if (r_lines[w_idx][w].age == AW'(WAYS - 1)) w_vic = AW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) if (!r_lines[w_idx][w].valid) w_vic = AW'(w);
  end

  assign w_dirty_vic = r_lines[w_idx][w_vic].valid && r_lines[w_idx][w_vic].dirty;
  assign w_lookup    = r_state == LOOKUP && i_cpu_req;
  assign w_hit_ok    = w_lookup && w_hit;
  assign w_miss      = w_lookup && !w_hit;
  assign w_wb_ack    = r_state == WRITEBACK && i_mem_ack;
  assign w_fill      = r_state == REFILL && i_mem_ack;
  assign w_upd       = w_hit_ok || w_fill;
  assign w_acc       = w_fill ? r_victim : w_hit_way;
  assign w_word      = r_lines[w_idx][w_hit_way].block[w_off];
  assign o_cpu_ready = w_hit_ok;
  assign o_cpu_rdata = w_hit_ok ? w_word : '0;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  assoc_cache_lru #(.WAYS(WAYS)) u_lru (
    .i_ages (w_ages),
    .i_way  (w_acc),
    .o_ages (w_new_ages)
  );

  always_comb begin
    w_next = r_state;
    if (w_miss) w_next = w_dirty_vic ? WRITEBACK : REFILL;
    else if (w_wb_ack) w_next = REFILL;
    else if (w_fill) w_next = LOOKUP;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= LOOKUP;
    else r_state <= w_next;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_victim    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_miss) begin
      r_victim    <= w_vic;
      r_mem_req   <= 1'b1;
      r_mem_we    <= w_dirty_vic;
      r_mem_addr  <= w_dirty_vic ? {r_lines[w_idx][w_vic].tag, w_idx, {IDX_LO{1'b0}}}
                                 : {w_tag, w_idx, {IDX_LO{1'b0}}};
      r_mem_wdata <= w_dirty_vic ? r_lines[w_idx][w_vic].block : '0;
    end else if (w_wb_ack) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {w_tag, w_idx, {IDX_LO{1'b0}}};
      r_mem_wdata <= '0;
    end else if (w_fill) begin
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
    end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_lines <= RST_LINES;
    else begin
      if (w_upd) for (int w = 0; w < WAYS; w++) r_lines[w_idx][w].age <= w_new_ages[w];
      if (w_hit_ok && i_cpu_we) begin
        r_lines[w_idx][w_hit_way].block[w_off] <= merge_bytes(w_word, i_cpu_wdata, i_cpu_byte_mask);
        r_lines[w_idx][w_hit_way].dirty <= 1'b1;
      end
      if (w_fill) begin
        r_lines[w_idx][r_victim].valid <= 1'b1;
        r_lines[w_idx][r_victim].dirty <= 1'b0;
        r_lines[w_idx][r_victim].tag   <= w_tag;
        r_lines[w_idx][r_victim].block <= i_mem_rdata;
      end
    end

`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count, r_wb_count;
  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
  assign o_wb_count   = r_wb_count;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      if (w_hit_ok && ~&r_hit_count) r_hit_count <= r_hit_count + 32'd1;
      if (w_miss && ~&r_miss_count) r_miss_count <= r_miss_count + 32'd1;
      if (w_wb_ack && ~&r_wb_count) r_wb_count <= r_wb_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed scoreboard bench for assoc_cache (SETS=64, WAYS=2, WORDS=2).
module tb_assoc_cache;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_mask = '0;
  logic [31:0] cpu_rdata, mem_addr;
  logic        cpu_ready, mem_req, mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  typedef struct {bit chk; logic [31:0] rd;} cpu_exp_t;
  typedef struct {logic we; logic [31:0] addr; logic [63:0] wd;} mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  logic [63:0] mem_model [logic [31:0]];
  int checks = 0, errors = 0;
  int ack_delay = 0;
  bit resp_en = 1'b1;

  always #5 clk = ~clk;

  assoc_cache #(.SETS(64), .WAYS(2), .WORDS(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .i_cpu_byte_mask(cpu_mask),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Lower-memory responder: acks each transfer after ack_delay waiting cycles
  initial begin : responder
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && resp_en) begin
        if (wait_cnt < ack_delay) wait_cnt++;
        else begin
          wait_cnt = 0;
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'h0;
        end
      end else wait_cnt = 0;
    end
  end

  initial begin : mon_cpu
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cpu_ready && cpu_req) begin
        if (cpu_q.size() == 0) chk("cpu_unexpected_ready", 1, 0);
        else begin
          e = cpu_q.pop_front();
          if (e.chk) chk("cpu_rdata", cpu_rdata, e.rd);
        end
      end
    end
  end

  initial begin : mon_mem
    mem_exp_t e;
    logic p_req = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0;
    forever begin
      @(negedge clk);
      if (mem_req && (!p_req || mem_we != p_we || mem_addr != p_addr)) begin
        if (mem_q.size() == 0) chk("mem_unexpected_xfer", {31'd0, mem_we, mem_addr}, 0);
        else begin
          e = mem_q.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wd);
        end
      end
      p_req = mem_req; p_we = mem_we; p_addr = mem_addr;
    end
  end

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [63:0] wd);
    mem_q.push_back('{we, a, wd});
  endtask

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, input logic [31:0] exp_rd, input int exp_lat,
                        input int stall);
    int n = 0;
    cpu_q.push_back('{!we, exp_rd});
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_mask = m;
    while (n < 200) begin
      @(negedge clk); n++;
      if (n > 1 && n <= stall + 1) begin
        chk("stall_mem_req", mem_req, 1);
        chk("stall_mem_addr", mem_addr, {a[31:3], 3'b000});
        chk("stall_cpu_ready", cpu_ready, 0);
      end
      if (cpu_ready) break;
    end
    if (!cpu_ready) chk("ready_timeout", 0, 1);
    else chk("latency", n, exp_lat);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mem_model[32'h100] = 64'hBBBB_BBBB_AAAA_AAAA;
    mem_model[32'h300] = 64'h3030_3031_3030_3030;
    mem_model[32'h500] = 64'h5050_5051_5050_5050;
    mem_model[32'h008] = 64'h0A0A_0A0B_0A0A_0A0A;
    mem_model[32'h208] = 64'h0B0B_0B0C_0B0B_0B0B;
    mem_model[32'h408] = 64'h0C0C_0C0D_0C0C_0C0C;
    mem_model[32'h010] = 64'h1010_1011_1010_1010;
    mem_model[32'h018] = 64'h1818_1819_1818_1818;
    mem_model[32'h218] = 64'h2828_2829_2828_2828;
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // clean miss, store hit, load hit
    exp_mem(0, 32'h100, 0);
    access(0, 32'h100, 0, 4'h0, 32'hAAAA_AAAA, 3, 0);
    access(1, 32'h104, 32'h1234_5678, 4'b0011, 0, 1, 0);
    access(0, 32'h104, 0, 4'h0, 32'hBBBB_5678, 1, 0);
    // third tag in set 0x20 evicts dirty 0x100
    exp_mem(0, 32'h300, 0);
    access(0, 32'h300, 0, 4'h0, 32'h3030_3030, 3, 0);
    exp_mem(1, 32'h100, 64'hBBBB_5678_AAAA_AAAA);
    exp_mem(0, 32'h500, 0);
    access(0, 32'h500, 0, 4'h0, 32'h5050_5050, 4, 0);
    // LRU ordering in set 1: A, B, A, C evicts B
    exp_mem(0, 32'h008, 0);
    access(0, 32'h008, 0, 4'h0, 32'h0A0A_0A0A, 3, 0);
    exp_mem(0, 32'h208, 0);
    access(0, 32'h208, 0, 4'h0, 32'h0B0B_0B0B, 3, 0);
    access(0, 32'h008, 0, 4'h0, 32'h0A0A_0A0A, 1, 0);
    exp_mem(0, 32'h408, 0);
    access(0, 32'h408, 0, 4'h0, 32'h0C0C_0C0C, 3, 0);
    access(0, 32'h00C, 0, 4'h0, 32'h0A0A_0A0B, 1, 0);
    exp_mem(0, 32'h208, 0);
    access(0, 32'h208, 0, 4'h0, 32'h0B0B_0B0B, 3, 0);
    // slow memory: ack held off for 10 cycles
    ack_delay = 10;
    exp_mem(0, 32'h010, 0);
    access(0, 32'h010, 0, 4'h0, 32'h1010_1010, 13, 10);
    ack_delay = 0;
    // store-miss makes 0x018 dirty, then reset lands mid-writeback
    exp_mem(0, 32'h018, 0);
    access(1, 32'h018, 32'hCAFE_F00D, 4'hF, 0, 3, 0);
    exp_mem(0, 32'h218, 0);
    access(0, 32'h218, 0, 4'h0, 32'h2828_2828, 3, 0);
    resp_en = 1'b0;
    exp_mem(1, 32'h018, 64'h1818_1819_CAFE_F00D);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h418;
    repeat (2) @(negedge clk);
    chk("wb_pending_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    exp_mem(0, 32'h018, 0);
    access(0, 32'h018, 0, 4'h0, 32'h1818_1818, 3, 0);
    repeat (3) @(negedge clk);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
